mem_arbiter: RTL

- Arbitrates a single-ported, multicycle unified memory between the fetch-side port (I) and the memory-stage port (D) of the 16-bit pipelined CPU.
- Sequences each access as issue → wait for memory response → return data and ready to the winner.
- The losing port stalls until it is served. D has priority, with a bounded-starvation override for I.

---
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch I / data D) arbiter for a single-ported multicycle memory, D-priority with
// bounded I starvation. Define MEM_ARBITER_STATS_EN to add saturating grant/conflict counters.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
`ifdef MEM_ARBITER_STATS_EN
  output logic [15:0]   stat_i_grants,
  output logic [15:0]   stat_d_grants,
  output logic [15:0]   stat_conflicts,
`endif
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  state_e          state_q, state_d;
  logic            owner_i_q, owner_i_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            i_ready_q, i_ready_d;
  logic            d_ready_q, d_ready_d;
  logic            grant_i, grant_d;

  always_comb begin
    state_d     = state_q;
    owner_i_d   = owner_i_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    grant_i     = 1'b0;
    grant_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // I wins when alone, or when D has been granted StarveMax times in a row over it.
        if (i_req && (!d_req || ((STARVE_MAX > 0) && (starve_q == StarveMax)))) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end

        if (grant_i) begin
          owner_i_d   = 1'b1;
          mem_addr_d  = i_addr;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          mem_en_d    = 1'b1;
          starve_d    = '0;
          state_d     = StIssue;
        end else if (grant_d) begin
          owner_i_d   = 1'b0;
          mem_addr_d  = d_addr;
          mem_we_d    = d_we;
          mem_wdata_d = d_wdata;
          mem_en_d    = 1'b1;
          state_d     = StIssue;
          if (!i_req) begin
            starve_d = '0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (mem_valid) begin
          if (owner_i_q) begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_ready_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_i_q   <= 1'b0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_i_q   <= owner_i_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] stat_i_q, stat_i_d;
  logic [15:0] stat_d_q, stat_d_d;
  logic [15:0] stat_c_q, stat_c_d;

  always_comb begin
    stat_i_d = stat_i_q;
    stat_d_d = stat_d_q;
    stat_c_d = stat_c_q;
    if (grant_i && (stat_i_q != 16'hFFFF)) stat_i_d = stat_i_q + 16'd1;
    if (grant_d && (stat_d_q != 16'hFFFF)) stat_d_d = stat_d_q + 16'd1;
    if ((state_q == StIdle) && i_req && d_req && (stat_c_q != 16'hFFFF)) begin
      stat_c_d = stat_c_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_i_q <= '0;
      stat_d_q <= '0;
      stat_c_q <= '0;
    end else begin
      stat_i_q <= stat_i_d;
      stat_d_q <= stat_d_d;
      stat_c_q <= stat_c_d;
    end
  end

  assign stat_i_grants  = stat_i_q;
  assign stat_d_grants  = stat_d_q;
  assign stat_conflicts = stat_c_q;
`endif

endmodule
